// File: rtl/stack_pkg.sv
// Shared definitions for the stack sequencer: op codes, FSM states
// and the stack-pointer register constants.
package stack_pkg;

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_CALL = 2'b10;
  localparam logic [1:0] OP_RET  = 2'b11;

  localparam logic [1:0] SP_REG   = 2'd3;
  localparam logic [7:0] SP_RESET = 8'hFF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PUSH_WR = 3'd1,
    POP_RD  = 3'd2,
    POP_WB  = 3'd3,
    SP_WB   = 3'd4
  } state_t;

  // PUSH and CALL both store to the stack.
  function automatic logic is_store(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/stack_ctrl.sv
// Multi-cycle PUSH/POP/CALL/RET sequencer beside the MEM stage.
// Drives the register-file write port and the synchronous data memory.
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int         DW     = 8,
  parameter logic [1:0] SP_ADR = SP_REG
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          Start,
  input  logic [1:0]    Op,
  input  logic [1:0]    Rd,
  input  logic [DW-1:0] SP_in,
  input  logic [DW-1:0] Data_in,
  input  logic [DW-1:0] Target,
  input  logic [DW-1:0] Mem_Dout,
  output logic [DW-1:0] Mem_Adr,
  output logic          Mem_WE,
  output logic [DW-1:0] Mem_Din,
  output logic          W_En,
  output logic [1:0]    W_Adr,
  output logic [DW-1:0] W_Data,
  output logic          PC_Load,
  output logic [DW-1:0] PC_out,
  output logic          Busy,
  output logic          Done,
  output logic          Err
);

  localparam logic [DW-1:0] ONE = DW'(1);
  localparam logic [DW-1:0] ALL = {DW{1'b1}};

  state_t        r_state;
  state_t        w_next;
  logic [1:0]    r_op;
  logic [1:0]    r_rd;
  logic [DW-1:0] r_sp;
  logic [DW-1:0] r_data;
  logic [DW-1:0] r_tgt;
  logic          r_err;

  logic          w_store;
  logic          w_fault;
  logic          w_accept;

  assign w_store  = is_store(Op);
  assign w_fault  = w_store ? (SP_in == '0)
                            : (SP_in == ALL);
  assign w_accept = (r_state == IDLE) && Start;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_op    <= '0;
      r_rd    <= '0;
      r_sp    <= '0;
      r_data  <= '0;
      r_tgt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op   <= Op;
        r_rd   <= Rd;
        r_sp   <= SP_in;
        r_data <= Data_in;
        r_tgt  <= Target;
        r_err  <= w_fault;
      end
    end
  end

  // A faulting request parks in SP_WB with r_err set, which
  // suppresses every write and only raises Done/Err.
  always_comb begin
    w_next  = r_state;
    Mem_Adr = '0;
    Mem_WE  = 1'b0;
    Mem_Din = '0;
    W_En    = 1'b0;
    W_Adr   = '0;
    W_Data  = '0;
    PC_Load = 1'b0;
    PC_out  = '0;
    Done    = 1'b0;
    Err     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (Start) begin
          if (w_fault)
            w_next = SP_WB;
          else if (w_store)
            w_next = PUSH_WR;
          else
            w_next = POP_RD;
        end
      end
      PUSH_WR: begin
        Mem_WE  = 1'b1;
        Mem_Adr = r_sp;
        Mem_Din = r_data;
        w_next  = SP_WB;
      end
      POP_RD: begin
        Mem_Adr = r_sp + ONE;
        w_next  = POP_WB;
      end
      POP_WB: begin
        w_next = SP_WB;
        if (r_op == OP_POP) begin
          W_En   = 1'b1;
          W_Adr  = r_rd;
          W_Data = Mem_Dout;
          if (r_rd == SP_ADR) begin
            Done   = 1'b1;
            w_next = IDLE;
          end
        end else begin
          PC_Load = 1'b1;
          PC_out  = Mem_Dout;
        end
      end
      SP_WB: begin
        Done   = 1'b1;
        w_next = IDLE;
        if (r_err) begin
          Err = 1'b1;
        end else begin
          W_En   = 1'b1;
          W_Adr  = SP_ADR;
          W_Data = is_store(r_op) ? r_sp - ONE
                                  : r_sp + ONE;
          if (r_op == OP_CALL) begin
            PC_Load = 1'b1;
            PC_out  = r_tgt;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign Busy = (r_state != IDLE);

endmodule

// File: tb/tb_stack_ctrl.sv
// Scoreboard bench for stack_ctrl with a register-file and
// synchronous-memory model wrapped around the DUT.
module tb_stack_ctrl;
  import stack_pkg::*;

  typedef struct packed {
    logic [7:0] adr;
    logic       we;
    logic [7:0] din;
    logic       wen;
    logic [1:0] wadr;
    logic [7:0] wdata;
    logic       pcl;
    logic [7:0] pco;
    logic       done;
    logic       err;
  } obs_t;

  logic       CLK = 1'b0;
  logic       RST;
  logic       Start;
  logic [1:0] Op;
  logic [1:0] Rd;
  logic [7:0] SP_in;
  logic [7:0] Data_in;
  logic [7:0] Target;
  logic [7:0] Mem_Dout;
  logic [7:0] Mem_Adr;
  logic       Mem_WE;
  logic [7:0] Mem_Din;
  logic       W_En;
  logic [1:0] W_Adr;
  logic [7:0] W_Data;
  logic       PC_Load;
  logic [7:0] PC_out;
  logic       Busy;
  logic       Done;
  logic       Err;

  logic [7:0] mem [256];
  logic [7:0] rf [4];
  logic       use_ovr;
  logic [7:0] ovr;

  obs_t  exp_q [$];
  string nm_q  [$];
  int    checks = 0;
  int    errors = 0;

  always #5 CLK = ~CLK;

  stack_ctrl #(.DW(8), .SP_ADR(SP_REG)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Op(Op), .Rd(Rd),
    .SP_in(SP_in), .Data_in(Data_in), .Target(Target),
    .Mem_Dout(Mem_Dout), .Mem_Adr(Mem_Adr), .Mem_WE(Mem_WE),
    .Mem_Din(Mem_Din), .W_En(W_En), .W_Adr(W_Adr),
    .W_Data(W_Data), .PC_Load(PC_Load), .PC_out(PC_out),
    .Busy(Busy), .Done(Done), .Err(Err)
  );

  always @(posedge CLK) begin
    if (Mem_WE) mem[Mem_Adr] <= Mem_Din;
    Mem_Dout <= mem[Mem_Adr];
  end

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      rf[0] <= 8'h00;
      rf[1] <= 8'h00;
      rf[2] <= 8'h00;
      rf[3] <= SP_RESET;
    end else if (W_En) begin
      rf[W_Adr] <= W_Data;
    end
  end

  assign SP_in = use_ovr ? ovr : rf[3];

  function automatic obs_t cur();
    return '{Mem_Adr, Mem_WE, Mem_Din, W_En, W_Adr, W_Data,
             PC_Load, PC_out, Done, Err};
  endfunction

  function automatic obs_t mk(
    input logic [7:0] adr, input logic we, input logic [7:0] din,
    input logic wen, input logic [1:0] wadr, input logic [7:0] wdata,
    input logic pcl, input logic [7:0] pco,
    input logic done, input logic err);
    return '{adr, we, din, wen, wadr, wdata, pcl, pco, done, err};
  endfunction

  task automatic expect_obs(input string nm, input obs_t o);
    exp_q.push_back(o);
    nm_q.push_back(nm);
  endtask

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, a, e);
    end
  endtask

  // Monitor: every busy cycle is one observed transaction.
  always @(negedge CLK) begin
    if (!RST && Busy) begin
      obs_t  a;
      obs_t  e;
      string n;
      a = cur();
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_busy_cycle got %h expected none", a);
      end else begin
        e = exp_q.pop_front();
        n = nm_q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL %s got %h expected %h", n, a, e);
        end
      end
    end
  end

  task automatic start_op(input logic [1:0] op, input logic [1:0] rd,
                          input logic [7:0] d, input logic [7:0] t);
    Op      = op;
    Rd      = rd;
    Data_in = d;
    Target  = t;
    Start   = 1'b1;
    @(posedge CLK); #1;
    Start   = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (Busy && n < 10) begin
      @(posedge CLK); #1;
      n++;
    end
    chk({nm, "_timeout"}, 64'(Busy), 64'd0);
    @(posedge CLK); #1;
  endtask

  initial begin
    RST = 1'b1; Start = 1'b0; Op = '0; Rd = '0;
    Data_in = '0; Target = '0; use_ovr = 1'b0; ovr = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_busy", 64'(Busy), 64'd0);
    chk("reset_outputs", 64'(cur()), 64'd0);
    RST = 1'b0;
    @(posedge CLK); #1;
    chk("idle_outputs", 64'(cur()), 64'd0);

    expect_obs("push_wr", mk(8'hFF,1,8'hA5, 0,0,8'h00, 0,8'h00, 0,0));
    expect_obs("push_sp", mk(8'h00,0,8'h00, 1,3,8'hFE, 0,8'h00, 1,0));
    start_op(OP_PUSH, 2'd0, 8'hA5, 8'h00);
    wait_idle("push");

    expect_obs("pop_rd", mk(8'hFF,0,8'h00, 0,0,8'h00, 0,8'h00, 0,0));
    expect_obs("pop_wb", mk(8'h00,0,8'h00, 1,1,8'hA5, 0,8'h00, 0,0));
    expect_obs("pop_sp", mk(8'h00,0,8'h00, 1,3,8'hFF, 0,8'h00, 1,0));
    start_op(OP_POP, 2'd1, 8'h00, 8'h00);
    wait_idle("pop");
    chk("pop_rf1", 64'(rf[1]), 64'hA5);

    expect_obs("call_wr", mk(8'hFF,1,8'h11, 0,0,8'h00, 0,8'h00, 0,0));
    expect_obs("call_sp", mk(8'h00,0,8'h00, 1,3,8'hFE, 1,8'h40, 1,0));
    start_op(OP_CALL, 2'd0, 8'h11, 8'h40);
    wait_idle("call");

    expect_obs("ret_rd", mk(8'hFF,0,8'h00, 0,0,8'h00, 0,8'h00, 0,0));
    expect_obs("ret_wb", mk(8'h00,0,8'h00, 0,0,8'h00, 1,8'h11, 0,0));
    expect_obs("ret_sp", mk(8'h00,0,8'h00, 1,3,8'hFF, 0,8'h00, 1,0));
    start_op(OP_RET, 2'd0, 8'h00, 8'h00);
    wait_idle("ret");

    expect_obs("underflow", mk(8'h00,0,8'h00, 0,0,8'h00, 0,8'h00, 1,1));
    start_op(OP_POP, 2'd2, 8'h00, 8'h00);
    wait_idle("underflow");
    chk("underflow_sp", 64'(rf[3]), 64'hFF);

    use_ovr = 1'b1; ovr = 8'h00;
    expect_obs("overflow", mk(8'h00,0,8'h00, 0,0,8'h00, 0,8'h00, 1,1));
    start_op(OP_PUSH, 2'd0, 8'h99, 8'h00);
    wait_idle("overflow");
    use_ovr = 1'b0;
    chk("overflow_sp", 64'(rf[3]), 64'hFF);

    expect_obs("push7c_wr", mk(8'hFF,1,8'h7C, 0,0,8'h00, 0,8'h00, 0,0));
    expect_obs("push7c_sp", mk(8'h00,0,8'h00, 1,3,8'hFE, 0,8'h00, 1,0));
    start_op(OP_PUSH, 2'd0, 8'h7C, 8'h00);
    wait_idle("push7c");

    expect_obs("pop3_rd", mk(8'hFF,0,8'h00, 0,0,8'h00, 0,8'h00, 0,0));
    expect_obs("pop3_wb", mk(8'h00,0,8'h00, 1,3,8'h7C, 0,8'h00, 1,0));
    start_op(OP_POP, 2'd3, 8'h00, 8'h00);
    wait_idle("pop3");
    chk("pop3_rf3", 64'(rf[3]), 64'h7C);

    expect_obs("busy_wr", mk(8'h7C,1,8'h33, 0,0,8'h00, 0,8'h00, 0,0));
    expect_obs("busy_sp", mk(8'h00,0,8'h00, 1,3,8'h7B, 0,8'h00, 1,0));
    start_op(OP_PUSH, 2'd0, 8'h33, 8'h00);
    Op = OP_POP; Rd = 2'd1; Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    wait_idle("busy_ignore");
    chk("busy_ignore_idle", 64'(Busy), 64'd0);
    chk("busy_ignore_sp", 64'(rf[3]), 64'h7B);

    expect_obs("rst_rd", mk(8'h7C,0,8'h00, 0,0,8'h00, 0,8'h00, 0,0));
    start_op(OP_POP, 2'd1, 8'h00, 8'h00);
    @(posedge CLK); #1;
    RST = 1'b1;
    #1;
    chk("rst_mid_busy", 64'(Busy), 64'd0);
    chk("rst_mid_outputs", 64'(cur()), 64'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;

    expect_obs("post_wr", mk(8'hFF,1,8'h5A, 0,0,8'h00, 0,8'h00, 0,0));
    expect_obs("post_sp", mk(8'h00,0,8'h00, 1,3,8'hFE, 0,8'h00, 1,0));
    start_op(OP_PUSH, 2'd0, 8'h5A, 8'h00);
    wait_idle("post_rst");
    chk("post_rst_sp", 64'(rf[3]), 64'hFE);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stack_ctrl.md
# stack_ctrl

- Multi-cycle sequencer for PUSH, POP, CALL and RET.
- Drives the register-file write port (W_En/W_Adr/W_Data) and the synchronous data memory.
- Reads the stack pointer from register-file R3 (reset 8'hFF).
- Sits beside the MEM stage; the pipeline stalls on Busy until Done pulses.
- Stack is empty-descending: SP points at the next free byte. PUSH writes then decrements; POP increments then reads.

## Interface
Parameters:
- DW, 8, data/address width
- SP_ADR, 2'd3, register index holding SP

Ports:
- CLK  in  1  single clock, rising edge
- RST  in  1  asynchronous, active-high reset
- Start  in  1  request strobe; sampled only in IDLE
- Op  in  2  00 PUSH, 01 POP, 10 CALL, 11 RET
- Rd  in  2  destination register for POP
- SP_in  in  8  current SP (register-file R3 read)
- Data_in  in  8  value to push (PUSH) or return address (CALL)
- Target  in  8  CALL jump address
- Mem_Dout  in  8  memory read data, valid one cycle after Mem_Adr
- Mem_Adr  out  8  memory address
- Mem_WE  out  1  memory write enable
- Mem_Din  out  8  memory write data
- W_En  out  1  register-file write enable
- W_Adr  out  2  register-file write address
- W_Data  out  8  register-file write data
- PC_Load  out  1  load PC_out into PC this cycle
- PC_out  out  8  new PC value
- Busy  out  1  state != IDLE
- Done  out  1  one-cycle completion pulse
- Err  out  1  one-cycle overflow/underflow pulse, coincident with Done

## Operation
- States: IDLE, PUSH_WR, POP_RD, POP_WB, SP_WB.
- All outputs are Moore-decoded from state and latched operands.
- Every output is 0 in IDLE and at reset.

Accept and latch:
- In IDLE with Start=1, latch Op, Rd, SP_in, Data_in, Target.
- PUSH/CALL go to PUSH_WR; POP/RET go to POP_RD.

PUSH_WR:
- Mem_WE=1, Mem_Adr=SP, Mem_Din=Data.
- Next state: SP_WB.

SP_WB:
- W_En=1, W_Adr=SP_ADR, W_Data=SP-1 for PUSH/CALL, SP+1 for POP/RET.
- CALL additionally drives PC_Load=1, PC_out=Target.
- Done=1; next state: IDLE.

POP_RD:
- Mem_Adr=SP+1 (8-bit).
- Next state: POP_WB.

POP_WB:
- POP: W_En=1, W_Adr=Rd, W_Data=Mem_Dout.
- RET: PC_Load=1, PC_out=Mem_Dout.
- Next state: SP_WB.
- POP with Rd==SP_ADR: SP_WB is skipped. Done=1 in POP_WB, then IDLE. Final R3 = popped value.

Errors:
- Overflow: PUSH/CALL with SP==8'h00 → no memory write, no SP write, no PC_Load. Done=1 and Err=1 for one cycle, then IDLE.
- Underflow: POP/RET with SP==8'hFF → same treatment (no writes, Done+Err).
- These checks mean SP arithmetic never wraps.

Concurrency and reset:
- Start while Busy is ignored and not queued.
- The caller must not write R3 while Busy.
- RST mid-operation: immediately IDLE, all outputs 0. Partial effects already written (e.g. a memory byte) are not undone.

## Timing
Cycle 0 is the Start edge.

- PUSH: cycle 1 PUSH_WR, cycle 2 SP_WB (Done). Latency 2; next Start accepted cycle 3.
- CALL: same as PUSH, with PC_Load in cycle 2.
- POP: cycle 1 POP_RD, cycle 2 POP_WB, cycle 3 SP_WB (Done). Latency 3. With Rd=3, latency 2.
- RET: same as POP, with PC_Load in cycle 2 and SP write in cycle 3.
- Error: Done+Err in cycle 1.
- Busy=1 from cycle 1 through the Done cycle inclusive.
- Memory read latency is exactly one cycle; no handshake with memory.

## Structure
- Shared package `stack_pkg` holds:
  - op encodings OP_PUSH/OP_POP/OP_CALL/OP_RET;
  - state enum;
  - SP_REG = 2'd3;
  - SP_RESET = 8'hFF.
- The register file reset value of R3 uses SP_RESET from this package.
- Single flat module; no sub-module. The next-state logic and output decode are one FSM.

## Test plan
- After reset, SP_in=FF. PUSH Data_in=8'hA5 → cycle 1: Mem_WE=1, Mem_Adr=FF, Mem_Din=A5. Cycle 2: W_En=1, W_Adr=3, W_Data=FE, Done=1.
- POP Rd=1 with SP_in=FE, memory[FF]=A5 → cycle 1: Mem_Adr=FF. Cycle 2: W_Adr=1, W_Data=A5. Cycle 3: W_Adr=3, W_Data=FF, Done.
- CALL Data_in=8'h11, Target=8'h40, SP=FF → mem[FF]=11, SP write FE, PC_Load=1 with PC_out=40 in cycle 2. Then RET with SP=FE → PC_Load=1, PC_out=11 in cycle 2; SP write FF in cycle 3.
- Boundaries:
  - PUSH with SP=00 → Done=Err=1 in cycle 1; no Mem_WE, no W_En.
  - POP with SP=FF → same response.
  - POP Rd=3 with mem[FF]=7C, SP=FE → single W_En to R3 with 7C, Done in cycle 2.
- Start pulsed while Busy is ignored.
- RST asserted in POP_WB → outputs 0 the same cycle, Busy=0. A fresh PUSH then completes normally.
